// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-side arbiter and related schedulers.
//   arb_state_t : arbiter FSM states
//   id_width()  : source-ID width for n requesters, never below 1 bit
//   DATA_LSB / LAST_OFS / ID_OFS : layout of the packed {id, last, data} FIFO word.
//     Data sits at DATA_LSB. The LAST flag and the ID LSB are placed at the
//     given offsets above the top data bit.
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE    = 1'b0,
    ARB_GRANTED = 1'b1
  } arb_state_t;

  localparam int DATA_LSB = 0;
  localparam int LAST_OFS = 0;
  localparam int ID_OFS   = 1;

  function automatic int id_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req    in  N    request vector
//   ptr    in  IDW  index where the search starts (searches upward, wraps mod N)
//   onehot out N    one-hot winner (zero if nothing requested)
//   idx    out IDW  winner index
//   found  out 1    at least one request was set
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = id_width(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] idx,
  output logic           found
);

  logic [IDW-1:0] cand;

  // Walk the N positions starting at ptr; the first requester found wins.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = '0;
    for (int i = 0; i < N; i++) begin
      cand = IDW'((int'(ptr) + i) % N);
      if (!found && req[cand]) begin
        found        = 1'b1;
        idx          = cand;
        onehot[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin sharing of one async-FIFO write port among N
// requesters. A winner keeps the port for a whole packet or MAX_BEATS beats.
//   WCLK        in  1            write-domain clock
//   WRESETn     in  1            asynchronous active-low reset
//   REQ_VALID   in  N            per-requester valid
//   REQ_DATA    in  N*WIDTH      payload, requester i at [i*WIDTH +: WIDTH]
//   REQ_LAST    in  N            last beat of packet
//   REQ_READY   out N            per-requester ready (only the owner can be high)
//   FIFO_WDATA  out WIDTH+IDW+1  {id, last, data}
//   FIFO_WVALID out 1            FIFO write valid
//   FIFO_WREADY in  1            FIFO not full
//   GRANT       out N            one-hot owner, zero when idle
//   BUSY        out 1            a grant is active
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N         = 4,
  parameter  int WIDTH     = 32,
  parameter  int MAX_BEATS = 16,
  localparam int IDW       = id_width(N)
) (
  input  logic                   WCLK,
  input  logic                   WRESETn,
  input  logic [N-1:0]           REQ_VALID,
  input  logic [N*WIDTH-1:0]     REQ_DATA,
  input  logic [N-1:0]           REQ_LAST,
  output logic [N-1:0]           REQ_READY,
  output logic [WIDTH+IDW:0]     FIFO_WDATA,
  output logic                   FIFO_WVALID,
  input  logic                   FIFO_WREADY,
  output logic [N-1:0]           GRANT,
  output logic                   BUSY
);

  localparam int CNTW = $clog2(MAX_BEATS + 1);

  arb_state_t     state, state_n;
  logic [N-1:0]   grant, grant_n;
  logic [IDW-1:0] owner, owner_n;
  logic [IDW-1:0] rr_ptr, rr_ptr_n;
  logic [CNTW-1:0] beat_cnt, beat_cnt_n;

  logic [N-1:0]     pick_onehot;
  logic [IDW-1:0]   pick_idx;
  logic             pick_found;
  logic             owner_valid;
  logic             owner_last;
  logic [WIDTH-1:0] owner_data;
  logic             handshake;
  logic             release_beat;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .req    (REQ_VALID),
    .ptr    (rr_ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  // Select the owner's request signals with constant-index compares.
  always_comb begin
    owner_valid = 1'b0;
    owner_last  = 1'b0;
    owner_data  = '0;
    for (int i = 0; i < N; i++) begin
      if (owner == IDW'(i)) begin
        owner_valid = REQ_VALID[i];
        owner_last  = REQ_LAST[i];
        owner_data  = REQ_DATA[i*WIDTH +: WIDTH];
      end
    end
  end

  assign BUSY        = (state == ARB_GRANTED);
  assign GRANT       = grant;
  assign FIFO_WVALID = BUSY && owner_valid;
  assign REQ_READY   = grant & {N{FIFO_WREADY}};
  assign handshake   = FIFO_WVALID && FIFO_WREADY;
  // The counter is checked against MAX_BEATS-1 so it never reaches a wrap.
  assign release_beat = handshake &&
                        (owner_last || (beat_cnt == CNTW'(MAX_BEATS - 1)));

  always_comb begin
    FIFO_WDATA = '0;
    if (BUSY) begin
      FIFO_WDATA[DATA_LSB +: WIDTH]     = owner_data;
      FIFO_WDATA[WIDTH + LAST_OFS]      = owner_last;
      FIFO_WDATA[WIDTH + ID_OFS +: IDW] = owner;
    end
  end

  always_comb begin
    state_n    = state;
    grant_n    = grant;
    owner_n    = owner;
    rr_ptr_n   = rr_ptr;
    beat_cnt_n = beat_cnt;
    case (state)
      ARB_IDLE: begin
        if (pick_found) begin
          state_n    = ARB_GRANTED;
          grant_n    = pick_onehot;
          owner_n    = pick_idx;
          beat_cnt_n = '0;
        end
      end
      ARB_GRANTED: begin
        if (release_beat) begin
          state_n    = ARB_IDLE;
          grant_n    = '0;
          beat_cnt_n = '0;
          // Next search starts just past the releasing owner.
          rr_ptr_n   = (owner == IDW'(N - 1)) ? '0 : owner + 1'b1;
        end else if (handshake) begin
          beat_cnt_n = beat_cnt + 1'b1;
        end
      end
      default: state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge WCLK or negedge WRESETn) begin
    if (!WRESETn) begin
      state    <= ARB_IDLE;
      grant    <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_n;
      grant    <= grant_n;
      owner    <= owner_n;
      rr_ptr   <= rr_ptr_n;
      beat_cnt <= beat_cnt_n;
    end
  end

endmodule
